// File: rtl/fifo_rd_streamer_if.sv
// FIFO read port plus output valid/ready stream, grouped for fifo_rd_streamer.
// master = streamer side, slave = environment (FIFO + consumer) side.
interface fifo_rd_streamer_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              o_rden;
    logic [DATA_W-1:0] i_rddata;
    logic              i_empty;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_data;
    logic [CNT_W-1:0]  o_xfer_cnt;

    modport master (
        output o_rden,
        input  i_rddata,
        input  i_empty,
        output o_valid,
        input  i_ready,
        output o_data,
        output o_xfer_cnt
    );

    modport slave (
        input  o_rden,
        output i_rddata,
        output i_empty,
        input  o_valid,
        output i_ready,
        input  o_data,
        input  o_xfer_cnt
    );
endinterface

// File: rtl/fifo_rd_streamer.sv
// Drains a 1-cycle-latency sync FIFO into a valid/ready stream via a 2-entry buffer; first word visible 2 cycles after !empty.
// Reads are throttled so buffered + in-flight words never exceed 2; output holds steady under backpressure. rstn is active-high.
module fifo_rd_streamer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rstn,
    fifo_rd_streamer_if.master  bus
);

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_inflight;
    logic [DATA_W-1:0]   r_buf0;
    logic [DATA_W-1:0]   r_buf1;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_valid;
    logic                w_xfer;
    logic                w_cap;
    logic                w_rden;
    logic [1:0]          w_words;
    logic [1:0]          w_occ;

    assign w_valid = (r_state != BUF_EMPTY);
    assign w_xfer  = w_valid && bus.i_ready;
    assign w_cap   = r_inflight;

    always_comb begin
        w_words = 2'd0;
        case (r_state)
            BUF_EMPTY: w_words = 2'd0;
            BUF_ONE:   w_words = 2'd1;
            default:   w_words = 2'd2;
        endcase
    end

    // Occupancy as it will stand after this edge's capture/accept; a new read must keep it <= 2.
    assign w_occ  = w_words + {1'b0, r_inflight} - {1'b0, w_xfer};
    assign w_rden = !rstn && !bus.i_empty && (w_occ < 2'd2);

    // State register
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            BUF_EMPTY: if (w_cap) w_next = BUF_ONE;
            BUF_ONE: begin
                if (w_cap && !w_xfer)      w_next = BUF_TWO;
                else if (!w_cap && w_xfer) w_next = BUF_EMPTY;
            end
            default:   if (!w_cap && w_xfer) w_next = BUF_ONE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.o_valid    = w_valid;
        bus.o_rden     = w_rden;
        bus.o_data     = r_buf0;
        bus.o_xfer_cnt = r_cnt;
    end

    // r_buf0 always holds the oldest word so o_data comes straight from a register.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_inflight <= 1'b0;
            r_buf0     <= '0;
            r_buf1     <= '0;
            r_cnt      <= '0;
        end else begin
            r_inflight <= w_rden;
            if (w_xfer) r_cnt <= r_cnt + CNT_W'(1);
            case (r_state)
                BUF_EMPTY: begin
                    if (w_cap) r_buf0 <= bus.i_rddata;
                end
                BUF_ONE: begin
                    if (w_cap) begin
                        if (w_xfer) r_buf0 <= bus.i_rddata;
                        else        r_buf1 <= bus.i_rddata;
                    end
                end
                default: begin
                    if (w_xfer) begin
                        r_buf0 <= r_buf1;
                        if (w_cap) r_buf1 <= bus.i_rddata;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/fifo_rd_streamer.md
FIFO_RD_STREAMER -- requirements
Module: fifo_rd_streamer

Interface
REQ-001 Parameter DATA_W, default 32: width of FIFO read data and output stream data.
REQ-002 Parameter CNT_W, default 16: width of delivered-word counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rstn  input  1  asynchronous, active-high reset; asserted = 1.
REQ-005 o_rden  output  1  read enable to upstream synchronous FIFO.
REQ-006 i_rddata  input  DATA_W  FIFO read data; valid exactly one cycle after o_rden was high.
REQ-007 i_empty  input  1  FIFO empty flag.
REQ-008 o_valid  output  1  output stream word available.
REQ-009 i_ready  input  1  downstream consumer accepts word.
REQ-010 o_data  output  DATA_W  output stream word.
REQ-011 o_xfer_cnt  output  CNT_W  count of words accepted downstream.

Function
REQ-012 Block shall drain the FIFO into a valid/ready stream with zero bubbles at sustained throughput of one word per clock.
REQ-013 Block shall hold a 2-entry output buffer; states BUF_EMPTY (0 words), BUF_ONE (1), BUF_TWO (2).
REQ-014 Block shall register a 1-bit in-flight flag equal to o_rden of the previous cycle.
REQ-015 o_rden shall be combinational: high iff !i_empty and (buffer words + in-flight) < 2 after accounting for an accept this cycle (o_valid && i_ready).
REQ-016 o_rden shall never assert while i_empty = 1.
REQ-017 When in-flight = 1, i_rddata shall be written into the buffer that cycle; it shall never be dropped.
REQ-018 o_valid shall be high iff state != BUF_EMPTY; o_data shall be the oldest buffered word, driven from a register.
REQ-019 Transfer occurs when o_valid && i_ready; oldest word removed; order preserved (FIFO order).
REQ-020 Transitions: BUF_EMPTY->BUF_ONE on capture; BUF_ONE->BUF_TWO on capture without transfer; BUF_ONE->BUF_EMPTY on transfer without capture; BUF_TWO->BUF_ONE on transfer without capture; capture plus transfer keeps state.
REQ-021 Capture while BUF_TWO with no transfer shall be impossible by construction of REQ-015.
REQ-022 o_data and o_valid shall stay stable while o_valid && !i_ready.
REQ-023 Latency: first word appears on o_valid two cycles after i_empty deasserts (rden cycle, capture cycle, then visible).
REQ-024 o_xfer_cnt shall increment by 1 per transfer, wrapping modulo 2^CNT_W without saturation.

Reset
REQ-025 On rstn = 1, asynchronously: state BUF_EMPTY, in-flight 0, o_valid 0, o_data 0, o_xfer_cnt 0; o_rden 0 while rstn = 1.
REQ-026 Reset mid-operation shall discard buffered and in-flight words; FIFO data already read is lost.
REQ-027 First o_rden after reset release shall be no earlier than the first rising edge with rstn = 0.

Verification
REQ-028 FIFO preloaded with 0x1..0x8, i_ready = 1 constantly -> o_rden high 8 consecutive cycles, o_data 0x1..0x8 on consecutive cycles, o_xfer_cnt = 8.
REQ-029 Preload 0xA,0xB,0xC, i_ready = 0 -> exactly two FIFO reads, o_valid = 1, o_data holds 0xA, i_empty stays 0; raise i_ready -> 0xA,0xB,0xC delivered in order.
REQ-030 i_ready toggling 1,0,1,0 with 6 preloaded words -> no loss, no duplication, order 1..6 preserved.
REQ-031 FIFO empty throughout -> o_rden never asserts, o_valid stays 0.
REQ-032 Assert rstn while BUF_TWO and in-flight = 1 -> o_valid 0, o_xfer_cnt 0 immediately, without waiting for a clock edge.
REQ-033 CNT_W = 4, 17 transfers -> o_xfer_cnt = 1 (wrap).
